// File: rtl/etapa_pipe_skid_if.sv
// etapa_pipe_skid_if: valid/ready handshake bundle.
// master drives upstream data and downstream ready.
interface etapa_pipe_skid_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
) ();
  logic [DATA_W*LANES-1:0] data_in;
  logic                    valid_in;
  logic                    ready_out;
  logic [DATA_W*LANES-1:0] data_out;
  logic                    valid_out;
  logic                    ready_in;

  modport master (
    output data_in,
    output valid_in,
    output ready_in,
    input  ready_out,
    input  data_out,
    input  valid_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    input  ready_in,
    output ready_out,
    output data_out,
    output valid_out
  );
endinterface

// File: rtl/etapa_pipe_skid.sv
// etapa_pipe_skid: registered valid/ready slice.
// SKID=1 adds a second entry for full throughput.
module etapa_pipe_skid #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk_8f,
  input  logic              reset,
  etapa_pipe_skid_if.slave  bus,
  input  logic              clr_stats,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_count
);
  localparam int W = DATA_W * LANES;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;
  logic [15:0]    stall_q, stall_d;
  logic           xfer_in;
  logic           xfer_out;

  assign xfer_in  = bus.valid_in & bus.ready_out;
  assign xfer_out = bus.valid_out & bus.ready_in;
  assign bus.data_out = main_q;
  assign stall_count  = stall_q;

  // state register
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and entry loads
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (xfer_in) begin
          main_d  = bus.data_in;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (xfer_in && xfer_out) begin
          main_d = bus.data_in;
        end else if (xfer_in) begin
          skid_d  = bus.data_in;
          state_d = FULL;
        end else if (xfer_out) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer_out) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // outputs decoded from registered state only
  always_comb begin
    bus.ready_out = 1'b0;
    bus.valid_out = 1'b0;
    occupancy     = 2'd0;
    unique case (state_q)
      EMPTY: begin
        bus.ready_out = 1'b1;
      end
      BUSY: begin
        bus.ready_out = SKID;
        bus.valid_out = 1'b1;
        occupancy     = 2'd1;
      end
      FULL: begin
        bus.valid_out = 1'b1;
        occupancy     = 2'd2;
      end
      default: ;
    endcase
  end

  // saturating stall counter, clear wins
  always_comb begin
    stall_d = stall_q;
    if (clr_stats) begin
      stall_d = 16'd0;
    end else if (bus.valid_out && !bus.ready_in &&
                 stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // datapath and statistics registers
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= 16'd0;
    end else begin
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_etapa_pipe_skid.sv
// tb_etapa_pipe_skid: four slices (skid, no skid,
// 1x1 and 16x8) against a queue reference model.
module tb_etapa_pipe_skid;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         clr;
  logic         vin  [4];
  logic         rin  [4];
  logic [127:0] din  [4];
  logic         vout [4];
  logic         rout [4];
  logic [127:0] dout [4];
  logic [1:0]   occ  [4];
  logic [15:0]  st   [4];

  int checks = 0;
  int fails  = 0;

  // reference model: accepted words in order
  logic [127:0] mem  [4][256];
  int           wr   [4];
  int           rd   [4];
  logic [127:0] last [4];
  logic [15:0]  sc   [4];
  logic [127:0] va   [4];
  logic [127:0] vb   [4];

  etapa_pipe_skid_if #(.DATA_W(8), .LANES(4)) b0 ();
  etapa_pipe_skid_if #(.DATA_W(8), .LANES(4)) b1 ();
  etapa_pipe_skid_if #(.DATA_W(1), .LANES(1)) b2 ();
  etapa_pipe_skid_if #(.DATA_W(16), .LANES(8)) b3 ();

  assign b0.data_in  = din[0][31:0];
  assign b0.valid_in = vin[0];
  assign b0.ready_in = rin[0];
  assign vout[0] = b0.valid_out;
  assign rout[0] = b0.ready_out;
  assign dout[0] = {96'd0, b0.data_out};

  assign b1.data_in  = din[1][31:0];
  assign b1.valid_in = vin[1];
  assign b1.ready_in = rin[1];
  assign vout[1] = b1.valid_out;
  assign rout[1] = b1.ready_out;
  assign dout[1] = {96'd0, b1.data_out};

  assign b2.data_in  = din[2][0:0];
  assign b2.valid_in = vin[2];
  assign b2.ready_in = rin[2];
  assign vout[2] = b2.valid_out;
  assign rout[2] = b2.ready_out;
  assign dout[2] = {127'd0, b2.data_out};

  assign b3.data_in  = din[3];
  assign b3.valid_in = vin[3];
  assign b3.ready_in = rin[3];
  assign vout[3] = b3.valid_out;
  assign rout[3] = b3.ready_out;
  assign dout[3] = b3.data_out;

  etapa_pipe_skid #(.DATA_W(8), .LANES(4), .SKID(1'b1)) u0 (
    .clk_8f(clk), .reset(rst), .bus(b0.slave),
    .clr_stats(clr), .occupancy(occ[0]), .stall_count(st[0]));
  etapa_pipe_skid #(.DATA_W(8), .LANES(4), .SKID(1'b0)) u1 (
    .clk_8f(clk), .reset(rst), .bus(b1.slave),
    .clr_stats(clr), .occupancy(occ[1]), .stall_count(st[1]));
  etapa_pipe_skid #(.DATA_W(1), .LANES(1), .SKID(1'b1)) u2 (
    .clk_8f(clk), .reset(rst), .bus(b2.slave),
    .clr_stats(clr), .occupancy(occ[2]), .stall_count(st[2]));
  etapa_pipe_skid #(.DATA_W(16), .LANES(8), .SKID(1'b1)) u3 (
    .clk_8f(clk), .reset(rst), .bus(b3.slave),
    .clr_stats(clr), .occupancy(occ[3]), .stall_count(st[3]));

  function automatic logic [127:0] msk(int d, logic [127:0] v);
    if (d < 2) return {96'd0, v[31:0]};
    if (d == 2) return {127'd0, v[0]};
    return v;
  endfunction

  function automatic bit m_rdy(int d);
    int c;
    c = wr[d] - rd[d];
    if (d == 1) return c == 0;
    return c < 2;
  endfunction

  function automatic logic [127:0] m_out(int d);
    if (wr[d] - rd[d] > 0) return mem[d][rd[d] & 255];
    return last[d];
  endfunction

  // one rising edge; model advances from pre-edge inputs
  task automatic cyc();
    bit ti, to, vl;
    @(posedge clk);
    for (int d = 0; d < 4; d++) begin
      if (!rst) begin
        wr[d] = 0;
        rd[d] = 0;
        last[d] = '0;
        sc[d] = 16'd0;
      end else begin
        vl = (wr[d] - rd[d]) > 0;
        ti = vin[d] && m_rdy(d);
        to = vl && rin[d];
        if (clr) sc[d] = 16'd0;
        else if (vl && !rin[d] && sc[d] != 16'hFFFF)
          sc[d] = sc[d] + 16'd1;
        if (to) begin
          last[d] = mem[d][rd[d] & 255];
          rd[d]++;
        end
        if (ti) begin
          mem[d][wr[d] & 255] = msk(d, din[d]);
          wr[d]++;
        end
      end
    end
    #1;
  endtask

  task automatic drive(logic v, logic r, logic [127:0] x);
    for (int d = 0; d < 4; d++) begin
      vin[d] = v;
      rin[d] = r;
      din[d] = x;
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0);
    clr = 1'b0;
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clr = 1'b0;
    drive(1'b1, 1'b0, {4{32'hDEADBEEF}});
    repeat (3) cyc();
    for (int d = 0; d < 4; d++) begin
      checks += 5;
      if (vout[d] !== 1'b0) begin
        fails++;
        $display("FAIL rst_valid d=%0d got=%b exp=0", d, vout[d]);
      end
      if (rout[d] !== 1'b1) begin
        fails++;
        $display("FAIL rst_ready d=%0d got=%b exp=1", d, rout[d]);
      end
      if (occ[d] !== 2'd0) begin
        fails++;
        $display("FAIL rst_occ d=%0d got=%0d exp=0", d, occ[d]);
      end
      if (st[d] !== 16'd0) begin
        fails++;
        $display("FAIL rst_stall d=%0d got=%h exp=0", d, st[d]);
      end
      if (dout[d] !== 128'd0) begin
        fails++;
        $display("FAIL rst_data d=%0d got=%h exp=0", d, dout[d]);
      end
    end
    drive(1'b0, 1'b0, '0);
    rst = 1'b1;
  endtask

  task automatic test_streaming();
    logic [127:0] e;
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b1, 128'(i));
      cyc();
      for (int d = 0; d < 4; d++) begin
        if (d == 1) continue;
        e = msk(d, 128'(i));
        checks += 3;
        if (rout[d] !== 1'b1) begin
          fails++;
          $display("FAIL stream_ready d=%0d i=%0d got=%b exp=1",
                   d, i, rout[d]);
        end
        if (vout[d] !== 1'b1) begin
          fails++;
          $display("FAIL stream_valid d=%0d i=%0d got=%b exp=1",
                   d, i, vout[d]);
        end
        if (dout[d] !== e) begin
          fails++;
          $display("FAIL stream_data d=%0d i=%0d got=%h exp=%h",
                   d, i, dout[d], e);
        end
      end
    end
    drive(1'b0, 1'b1, '0);
    cyc();
    for (int d = 0; d < 4; d++) begin
      if (d == 1) continue;
      checks++;
      if (vout[d] !== 1'b0) begin
        fails++;
        $display("FAIL stream_end d=%0d got=%b exp=0", d, vout[d]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    va[0] = 128'h A1A2A3A4;
    vb[0] = 128'h B1B2B3B4;
    va[2] = 128'd1;
    vb[2] = 128'd0;
    va[3] = {4{32'hA1A2A3A4}};
    vb[3] = {4{32'hB1B2B3B4}};
    va[1] = va[0];
    vb[1] = vb[0];
    for (int s = 0; s < 5; s++) begin
      for (int d = 0; d < 4; d++) begin
        vin[d] = (s < 3);
        rin[d] = (s >= 3);
        din[d] = (s == 0) ? va[d] :
                 (s == 1) ? vb[d] : ~vb[d];
      end
      cyc();
      for (int d = 0; d < 4; d++) begin
        logic [1:0]   eo;
        logic [127:0] ed;
        if (d == 1) continue;
        eo = (s == 0) ? 2'd1 : (s < 3) ? 2'd2 :
             (s == 3) ? 2'd1 : 2'd0;
        ed = (s < 3) ? va[d] : vb[d];
        checks += 4;
        if (occ[d] !== eo) begin
          fails++;
          $display("FAIL bp_occ d=%0d s=%0d got=%0d exp=%0d",
                   d, s, occ[d], eo);
        end
        if (dout[d] !== ed) begin
          fails++;
          $display("FAIL bp_data d=%0d s=%0d got=%h exp=%h",
                   d, s, dout[d], ed);
        end
        if (rout[d] !== (eo != 2'd2)) begin
          fails++;
          $display("FAIL bp_ready d=%0d s=%0d got=%b exp=%b",
                   d, s, rout[d], eo != 2'd2);
        end
        if (vout[d] !== (eo != 2'd0)) begin
          fails++;
          $display("FAIL bp_valid d=%0d s=%0d got=%b exp=%b",
                   d, s, vout[d], eo != 2'd0);
        end
      end
    end
    checks++;
    if (st[0] !== 16'd2) begin
      fails++;
      $display("FAIL bp_stall got=%0d exp=2", st[0]);
    end
  endtask

  task automatic test_half_throughput();
    do_reset();
    checks += 2;
    if (rout[1] !== 1'b1) begin
      fails++;
      $display("FAIL half_ready0 got=%b exp=1", rout[1]);
    end
    if (vout[1] !== 1'b0) begin
      fails++;
      $display("FAIL half_valid0 got=%b exp=0", vout[1]);
    end
    for (int i = 0; i < 8; i++) begin
      logic         ev;
      logic [127:0] ed;
      drive(1'b1, 1'b1, 128'(32'h100 + i));
      cyc();
      ev = (i % 2 == 0);
      ed = ev ? 128'(32'h100 + i) : 128'(32'h100 + i - 1);
      checks += 3;
      if (vout[1] !== ev) begin
        fails++;
        $display("FAIL half_valid i=%0d got=%b exp=%b",
                 i, vout[1], ev);
      end
      if (rout[1] !== !ev) begin
        fails++;
        $display("FAIL half_ready i=%0d got=%b exp=%b",
                 i, rout[1], !ev);
      end
      if (dout[1] !== ed) begin
        fails++;
        $display("FAIL half_data i=%0d got=%h exp=%h",
                 i, dout[1], ed);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int d = 0; d < 4; d++) begin
        vin[d] = ($urandom_range(0, 3) != 0);
        rin[d] = ($urandom_range(0, 2) != 0);
        din[d] = {$urandom, $urandom, $urandom, $urandom};
      end
      clr = ($urandom_range(0, 15) == 0);
      cyc();
      for (int d = 0; d < 4; d++) begin
        int c;
        c = wr[d] - rd[d];
        checks += 5;
        if (vout[d] !== (c > 0)) begin
          fails++;
          $display("FAIL rnd_valid d=%0d n=%0d got=%b exp=%b",
                   d, n, vout[d], c > 0);
        end
        if (rout[d] !== m_rdy(d)) begin
          fails++;
          $display("FAIL rnd_ready d=%0d n=%0d got=%b exp=%b",
                   d, n, rout[d], m_rdy(d));
        end
        if (dout[d] !== m_out(d)) begin
          fails++;
          $display("FAIL rnd_data d=%0d n=%0d got=%h exp=%h",
                   d, n, dout[d], m_out(d));
        end
        if (occ[d] !== 2'(c)) begin
          fails++;
          $display("FAIL rnd_occ d=%0d n=%0d got=%0d exp=%0d",
                   d, n, occ[d], c);
        end
        if (st[d] !== sc[d]) begin
          fails++;
          $display("FAIL rnd_stall d=%0d n=%0d got=%0d exp=%0d",
                   d, n, st[d], sc[d]);
        end
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_stall_counter();
    do_reset();
    drive(1'b1, 1'b0, 128'h77);
    cyc();
    drive(1'b0, 1'b0, '0);
    repeat (69999) cyc();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (st[d] !== 16'hFFFF) begin
        fails++;
        $display("FAIL stall_sat d=%0d got=%h exp=ffff", d, st[d]);
      end
    end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    checks++;
    if (st[0] !== 16'd0) begin
      fails++;
      $display("FAIL stall_clr got=%h exp=0", st[0]);
    end
    cyc();
    checks++;
    if (st[0] !== 16'd1) begin
      fails++;
      $display("FAIL stall_after_clr got=%h exp=1", st[0]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b0, 128'h1111);
    cyc();
    drive(1'b1, 1'b0, 128'h2222);
    cyc();
    checks++;
    if (occ[0] !== 2'd2) begin
      fails++;
      $display("FAIL async_full got=%0d exp=2", occ[0]);
    end
    #2;
    rst = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      if (d == 1) continue;
      checks += 4;
      if (vout[d] !== 1'b0) begin
        fails++;
        $display("FAIL async_valid d=%0d got=%b exp=0", d, vout[d]);
      end
      if (occ[d] !== 2'd0) begin
        fails++;
        $display("FAIL async_occ d=%0d got=%0d exp=0", d, occ[d]);
      end
      if (rout[d] !== 1'b1) begin
        fails++;
        $display("FAIL async_ready d=%0d got=%b exp=1", d, rout[d]);
      end
      if (st[d] !== 16'd0) begin
        fails++;
        $display("FAIL async_stall d=%0d got=%0d exp=0", d, st[d]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 128'h5A5A5A5A);
    cyc();
    checks += 2;
    if (vout[0] !== 1'b1) begin
      fails++;
      $display("FAIL async_next_valid got=%b exp=1", vout[0]);
    end
    if (dout[0] !== 128'h5A5A5A5A) begin
      fails++;
      $display("FAIL async_next_data got=%h exp=5a5a5a5a", dout[0]);
    end
    drive(1'b0, 1'b1, '0);
    cyc();
    checks++;
    if (vout[0] !== 1'b0) begin
      fails++;
      $display("FAIL async_drain got=%b exp=0", vout[0]);
    end
  endtask

  initial begin
    rst = 1'b0;
    clr = 1'b0;
    drive(1'b0, 1'b0, '0);
    test_reset();
    test_streaming();
    test_backpressure();
    test_half_throughput();
    test_random();
    test_async_reset();
    test_stall_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
